// File: rtl/tia_dl_bank.sv
// Bank of sticky two-phase collision-style latches with a registered paired read port.
// Optional per-channel saturating hit counters are built when TIA_DL_HITCNT_EN is defined.
module tia_dl_bank #(
    parameter int CHANNELS = 15,
    parameter int RD_AW    = 4,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in,
    input  logic                      s1,
    input  logic                      s2,
    input  logic                      clr,
    input  logic                      rd_en,
    input  logic [RD_AW-1:0]          rd_addr,
    output logic [1:0]                rd_data,
    output logic                      rd_valid,
    output logic [CHANNELS-1:0]       latched
`ifdef TIA_DL_HITCNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0] hit_cnt
`endif
);

    // Read port has no backpressure: rd_en at an edge yields rd_valid=1 for the
    // following cycle with the pre-edge latch pair; rd_data holds while rd_en=0.
    localparam int PAIRS = 1 << RD_AW;
    localparam int PADW  = (2 * PAIRS > CHANNELS) ? 2 * PAIRS : CHANNELS;

    logic [CHANNELS-1:0] cap_q, cap_d;
    logic [CHANNELS-1:0] lat_q, lat_d;
    logic [1:0]          rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [PADW-1:0]     lat_pad;

    // Zero-padding makes absent channels and out-of-range pairs read as 0.
    assign lat_pad = PADW'(lat_q);

    always_comb begin
        cap_d      = cap_q;
        lat_d      = lat_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        if (clr) begin
            cap_d = '0;
            lat_d = '0;
        end else begin
            if (s1) cap_d = in | lat_q;
            if (s2) lat_d = cap_q;
        end
        if (rd_en) rd_data_d = lat_pad[{rd_addr, 1'b0} +: 2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q      <= '0;
            lat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            lat_q      <= lat_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign latched  = lat_q & {CHANNELS{~clr}};

`ifdef TIA_DL_HITCNT_EN
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    // Counts s2 commits of a set capture bit; saturates instead of wrapping.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (s2 && cap_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < CHANNELS; i++) hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_tia_dl_bank.sv
// Self-checking bench for tia_dl_bank: directed scenarios plus randomized traffic
// compared against a per-channel behavioural model.
module tb_tia_dl_bank;

    localparam int CH      = 15;
    localparam int AW      = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     in_s;
    logic              s1, s2, clr, rd_en;
    logic [AW-1:0]     rd_addr;
    logic [1:0]        rd_data;
    logic              rd_valid;
    logic [CH-1:0]     latched;
`ifdef TIA_DL_HITCNT_EN
    logic [CH*CW-1:0]  hit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bit          m_cap [CH];
    bit          m_lat [CH];
    int          m_cnt [CH];
    logic [1:0]  m_rd_data;
    logic        m_rd_valid;

    tia_dl_bank #(.CHANNELS(CH), .RD_AW(AW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_s),
        .s1       (s1),
        .s2       (s2),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .latched  (latched)
`ifdef TIA_DL_HITCNT_EN
        ,
        .hit_cnt  (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: one clock edge applied to each channel independently.
    function automatic void model_edge();
        bit old_lat [CH];
        bit old_cap [CH];
        int lo;
        old_lat = m_lat;
        old_cap = m_cap;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_cap[c] = 0;
                m_lat[c] = 0;
                m_cnt[c] = 0;
            end
            m_rd_data  = 2'b00;
            m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = rd_en;
            if (rd_en) begin
                lo = 2 * int'(rd_addr);
                m_rd_data[0] = (lo < CH) ? old_lat[lo] : 1'b0;
                m_rd_data[1] = (lo + 1 < CH) ? old_lat[lo + 1] : 1'b0;
            end
            for (int c = 0; c < CH; c++) begin
                if (clr) begin
                    m_cap[c] = 0;
                    m_lat[c] = 0;
                    m_cnt[c] = 0;
                end else begin
                    if (s2) begin
                        m_lat[c] = old_cap[c];
                        if (old_cap[c]) m_cnt[c] = (m_cnt[c] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[c] + 1;
                    end
                    if (s1) m_cap[c] = in_s[c] | old_lat[c];
                end
            end
        end
    endfunction

    function automatic logic [CH-1:0] model_latched();
        logic [CH-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c] = m_lat[c] & ~clr;
        return v;
    endfunction

    function automatic logic [CH*CW-1:0] model_hits();
        logic [CH*CW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*CW +: CW] = CW'(m_cnt[c]);
        return v;
    endfunction

    // Driver: apply inputs, take one edge, advance the model, settle past the edge.
    task automatic drive(input logic r, input logic [CH-1:0] i_v, input logic a1, input logic a2,
                         input logic c, input logic re, input logic [AW-1:0] ad);
        rst_n   = r;
        in_s    = i_v;
        s1      = a1;
        s2      = a2;
        clr     = c;
        rd_en   = re;
        rd_addr = ad;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, '1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, '1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
        drive(1'b0, CH'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        checks++;
        if (latched !== '0) begin
            errors++; $display("FAIL reset_latched got %h want %h", latched, 15'h0);
        end
        checks++;
        if (rd_data !== 2'b00) begin
            errors++; $display("FAIL reset_rd_data got %b want 00", rd_data);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid);
        end
`ifdef TIA_DL_HITCNT_EN
        checks++;
        if (hit_cnt !== '0) begin
            errors++; $display("FAIL reset_hit_cnt got %h want 0", hit_cnt);
        end
`endif
    endtask

    task automatic test_min_latency();
        drive(1'b1, 15'h0008, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (latched !== 15'h0000) begin
            errors++; $display("FAIL lat_after_s1 got %h want %h", latched, 15'h0000);
        end
        drive(1'b1, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (latched !== 15'h0008) begin
            errors++; $display("FAIL lat_after_s2 got %h want %h", latched, 15'h0008);
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 15'h0000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
            checks++;
            if (latched !== 15'h0008) begin
                errors++; $display("FAIL lat_hold cyc %0d got %h want %h", k, latched, 15'h0008);
            end
        end
    endtask

    task automatic test_s1_only();
        drive(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 15'h0020, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (latched !== 15'h0000) begin
                errors++; $display("FAIL s1_only cyc %0d got %h want %h", k, latched, 15'h0000);
            end
        end
        drive(1'b1, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (latched !== 15'h0020) begin
            errors++; $display("FAIL s2_commit got %h want %h", latched, 15'h0020);
        end
    endtask

    task automatic test_clr();
        drive(1'b1, '1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, '1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (latched !== 15'h7FFF) begin
            errors++; $display("FAIL clr_setup got %h want %h", latched, 15'h7FFF);
        end
        clr = 1'b1; s1 = 1'b1; s2 = 1'b1; in_s = '1; rd_en = 1'b1; rd_addr = 4'd0;
        #1;
        checks++;
        if (latched !== 15'h0000) begin
            errors++; $display("FAIL clr_comb_mask got %h want %h", latched, 15'h0000);
        end
        drive(1'b1, '1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
        checks++;
        if (rd_data !== 2'b11) begin
            errors++; $display("FAIL clr_read_pre_edge got %b want 11", rd_data);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (latched !== 15'h0000) begin
            errors++; $display("FAIL clr_after_edge got %h want %h", latched, 15'h0000);
        end
    endtask

    task automatic test_read();
        drive(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 15'h4001, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (latched !== 15'h4001) begin
            errors++; $display("FAIL read_setup got %h want %h", latched, 15'h4001);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        checks++;
        if (rd_data !== 2'b01 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL read_a0 got %b/%b want 01/1", rd_data, rd_valid);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        checks++;
        if (rd_data !== 2'b00 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL read_a1 got %b/%b want 00/1", rd_data, rd_valid);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        checks++;
        if (rd_data !== 2'b01 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL read_a7 got %b/%b want 01/1", rd_data, rd_valid);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        checks++;
        if (rd_data !== 2'b00 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL read_a9 got %b/%b want 00/1", rd_data, rd_valid);
        end
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        drive(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        checks++;
        if (rd_data !== 2'b01 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL read_hold got %b/%b want 01/0", rd_data, rd_valid);
        end
    endtask

`ifdef TIA_DL_HITCNT_EN
    task automatic test_hitcnt();
        drive(1'b1, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        drive(1'b1, 15'h0001, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 20; k++) drive(1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (hit_cnt !== {{(CH*CW-CW){1'b0}}, 4'hF}) begin
            errors++; $display("FAIL hitcnt_sat got %h want %h", hit_cnt, {{(CH*CW-CW){1'b0}}, 4'hF});
        end
        drive(1'b1, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (hit_cnt !== '0) begin
            errors++; $display("FAIL hitcnt_clr got %h want 0", hit_cnt);
        end
    endtask
`endif

    task automatic test_random();
        logic [CH-1:0] exp_lat;
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 79) != 0),
                  CH'($urandom & $urandom & $urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
            exp_lat = model_latched();
            checks++;
            if (latched !== exp_lat || rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
                errors++;
                $display("FAIL random cyc %0d got lat=%h rd=%b v=%b want lat=%h rd=%b v=%b",
                         k, latched, rd_data, rd_valid, exp_lat, m_rd_data, m_rd_valid);
            end
`ifdef TIA_DL_HITCNT_EN
            checks++;
            if (hit_cnt !== model_hits()) begin
                errors++; $display("FAIL random_hits cyc %0d got %h want %h", k, hit_cnt, model_hits());
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; in_s = '0; s1 = 1'b0; s2 = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        test_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        test_min_latency();
        test_s1_only();
        test_clr();
        test_read();
`ifdef TIA_DL_HITCNT_EN
        test_hitcnt();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
